ticket_queue: RTL and testbench

Customer ticket issuer and waiting-line buffer. It sits directly upstream of the counter dispatcher. On each customer arrival press it assigns the next ticket number and stores the number with the requested service time in a first-word-fall-through FIFO. The head entry, the empty flag and the pop strobe form the dispatcher-facing interface.

---
 rtl/ticket_queue.sv | 152 +++++++++++++++
 tb/tb_ticket_queue.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ticket_queue.sv
// ---------------------------------------------------------------------------
// ticket_queue
//
// Customer ticket issuer and waiting-line buffer feeding the counter
// dispatcher. Each rising edge of the arrival button claims the next ticket
// number. The number is stored with the customer's requested service time in
// a first-word-fall-through FIFO. The dispatcher sees the head entry
// combinationally and removes it with a one-cycle pop strobe.
//
// Ports:
//   clk           in   clock, all state updates on the rising edge
//   rst           in   synchronous active-high reset
//   arrive_in     in   synchronised arrival button level
//   st_in         in   service time for the arriving customer
//   re_in         in   pop strobe from the dispatcher
//   empty         out  FIFO holds no entries
//   full          out  FIFO holds DEPTH entries
//   qn_out        out  head ticket number, 0 while empty
//   qt_out        out  head service time, 0 while empty
//   count_out     out  current occupancy, 0..DEPTH
//   next_num_out  out  number the next accepted arrival will receive
//   drop_out      out  one-cycle pulse after an arrival rejected while full
// ---------------------------------------------------------------------------
module ticket_queue #(
    parameter int NUM_W      = 4,
    parameter int TIME_W     = 4,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  arrive_in,
    input  logic [TIME_W-1:0]     st_in,
    input  logic                  re_in,
    output logic                  empty,
    output logic                  full,
    output logic [NUM_W-1:0]      qn_out,
    output logic [TIME_W-1:0]     qt_out,
    output logic [DEPTH_LOG2:0]   count_out,
    output logic [NUM_W-1:0]      next_num_out,
    output logic                  drop_out
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int CNT_W = DEPTH_LOG2 + 1;

    localparam logic [CNT_W-1:0]      CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);
    localparam logic [NUM_W-1:0]      NUM_FIRST = NUM_W'(1);
    localparam logic [NUM_W-1:0]      NUM_LAST  = '1;
    localparam logic [TIME_W-1:0]     TIME_MIN  = TIME_W'(1);

    typedef struct packed {
        logic [NUM_W-1:0]  num;
        logic [TIME_W-1:0] tm;
    } entry_t;

    // Storage is deliberately left unreset; empty gating of the head outputs
    // keeps stale contents from ever being observed.
    entry_t mem_q [DEPTH];

    logic                  arrive_q,   arrive_d;
    logic [DEPTH_LOG2-1:0] wp_q,       wp_d;
    logic [DEPTH_LOG2-1:0] rp_q,       rp_d;
    logic [CNT_W-1:0]      count_q,    count_d;
    logic [NUM_W-1:0]      next_num_q, next_num_d;
    logic                  drop_q,     drop_d;

    logic                  push_req;
    logic                  pop;
    logic                  push;
    logic [TIME_W-1:0]     st_eff;
    entry_t                head;

    // Request qualification. A pop while full frees the slot the push needs,
    // so a full FIFO still accepts an arrival that coincides with a pop.
    always_comb begin
        push_req = arrive_in & ~arrive_q;
        pop      = re_in & (count_q != '0);
        push     = push_req & ((count_q != CNT_FULL) | pop);
        // A zero service time would look like "no work" downstream, so it is
        // stored as the minimum of one.
        st_eff   = (st_in == '0) ? TIME_MIN : st_in;
    end

    // Next-state computation for pointers, occupancy, numbering and drop.
    always_comb begin
        arrive_d   = arrive_in;
        wp_d       = wp_q;
        rp_d       = rp_q;
        count_d    = count_q;
        next_num_d = next_num_q;
        drop_d     = push_req & ~push;

        if (push) begin
            wp_d = wp_q + PTR_ONE;
            // Ticket 0 means "no customer", so numbering skips it on wrap.
            next_num_d = (next_num_q == NUM_LAST) ? NUM_FIRST
                                                  : next_num_q + NUM_FIRST;
        end

        if (pop) begin
            rp_d = rp_q + PTR_ONE;
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // State register. During reset the edge detector still tracks the button,
    // so a button held across reset release does not issue a ticket.
    always_ff @(posedge clk) begin
        if (rst) begin
            arrive_q   <= arrive_in;
            wp_q       <= '0;
            rp_q       <= '0;
            count_q    <= '0;
            next_num_q <= NUM_FIRST;
            drop_q     <= 1'b0;
        end else begin
            arrive_q   <= arrive_d;
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            count_q    <= count_d;
            next_num_q <= next_num_d;
            drop_q     <= drop_d;
        end
    end

    // Entry write; reset wins over a coincident push.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wp_q] <= '{num: next_num_q, tm: st_eff};
        end
    end

    // First-word-fall-through head and status flags.
    always_comb begin
        head         = mem_q[rp_q];
        empty        = (count_q == '0);
        full         = (count_q == CNT_FULL);
        qn_out       = empty ? '0 : head.num;
        qt_out       = empty ? '0 : head.tm;
        count_out    = count_q;
        next_num_out = next_num_q;
        drop_out     = drop_q;
    end

endmodule

// File: tb/tb_ticket_queue.sv
// ---------------------------------------------------------------------------
// tb_ticket_queue
//
// Self-checking bench for ticket_queue. A queue-based reference model tracks
// the waiting line and ticket numbering every cycle. A vector table covers
// reset, single arrival, empty-pop and mid-operation reset behaviour.
// Hand-written sequences cover full/drop, full push+pop, and number
// wraparound. A randomized phase runs last.
// ---------------------------------------------------------------------------
module tb_ticket_queue;

    logic       clk;
    logic       rst;
    logic       arriveIn;
    logic [3:0] stIn;
    logic       reIn;
    logic       empty;
    logic       full;
    logic [3:0] qnOut;
    logic [3:0] qtOut;
    logic [3:0] countOut;
    logic [3:0] nextNumOut;
    logic       dropOut;

    int compared;
    int mismatched;

    typedef struct packed {
        logic [3:0] num;
        logic [3:0] tm;
    } entryT;

    entryT modelQ[$];
    int    modelNext;
    bit    modelPrevArrive;
    bit    modelDrop;

    typedef struct {
        bit       rstV;
        bit       arrV;
        bit [3:0] stV;
        bit       reV;
        bit       expEmpty;
        bit       expFull;
        int       expQn;
        int       expQt;
        int       expCount;
        int       expNext;
        bit       expDrop;
    } vecT;

    vecT vecs[$];

    ticket_queue dut (
        .clk          (clk),
        .rst          (rst),
        .arrive_in    (arriveIn),
        .st_in        (stIn),
        .re_in        (reIn),
        .empty        (empty),
        .full         (full),
        .qn_out       (qnOut),
        .qt_out       (qtOut),
        .count_out    (countOut),
        .next_num_out (nextNumOut),
        .drop_out     (dropOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference model: plain queue semantics, one call per clock edge.
    task automatic modelStep(input bit rstV, input bit arrV, input bit [3:0] stV,
                             input bit reV);
        bit pushReq, doPop, doPush;
        entryT e;
        if (rstV) begin
            modelQ.delete();
            modelNext       = 1;
            modelPrevArrive = arrV;
            modelDrop       = 0;
            return;
        end
        pushReq = arrV && !modelPrevArrive;
        doPop   = reV && (modelQ.size() > 0);
        doPush  = pushReq && (modelQ.size() < 8 || doPop);
        if (doPop) void'(modelQ.pop_front());
        if (doPush) begin
            e.num = 4'(modelNext);
            e.tm  = (stV == 0) ? 4'd1 : stV;
            modelQ.push_back(e);
            modelNext = (modelNext == 15) ? 1 : modelNext + 1;
        end
        modelDrop       = pushReq && !doPush;
        modelPrevArrive = arrV;
    endtask

    task automatic checkModel();
        bit mEmpty;
        mEmpty = (modelQ.size() == 0);
        checkOutput("model.empty", empty, mEmpty);
        checkOutput("model.full", full, modelQ.size() == 8);
        checkOutput("model.count", countOut, modelQ.size());
        checkOutput("model.qn", qnOut, mEmpty ? 0 : modelQ[0].num);
        checkOutput("model.qt", qtOut, mEmpty ? 0 : modelQ[0].tm);
        checkOutput("model.next", nextNumOut, modelNext);
        checkOutput("model.drop", dropOut, modelDrop);
    endtask

    // Drive one cycle of inputs at the falling edge and check after the
    // following rising edge.
    task automatic applyStimulus(input bit rstV, input bit arrV,
                                 input bit [3:0] stV, input bit reV);
        @(negedge clk);
        rst      = rstV;
        arriveIn = arrV;
        stIn     = stV;
        reIn     = reV;
        modelStep(rstV, arrV, stV, reV);
        @(posedge clk);
        #1;
        checkModel();
    endtask

    task automatic addVec(input bit r, input bit a, input bit [3:0] s, input bit p,
                          input bit eE, input bit eF, input int eQn, input int eQt,
                          input int eCnt, input int eNext, input bit eDrop);
        vecT v;
        v.rstV = r; v.arrV = a; v.stV = s; v.reV = p;
        v.expEmpty = eE; v.expFull = eF; v.expQn = eQn; v.expQt = eQt;
        v.expCount = eCnt; v.expNext = eNext; v.expDrop = eDrop;
        vecs.push_back(v);
    endtask

    initial begin
        compared        = 0;
        mismatched      = 0;
        modelNext       = 1;
        modelPrevArrive = 0;
        modelDrop       = 0;
        rst             = 1'b1;
        arriveIn        = 1'b0;
        stIn            = 4'd0;
        reIn            = 1'b0;

        //     rst arr st  re   empty full qn qt cnt next drop
        addVec(1, 1, 0,  0,   1, 0, 0, 0, 0, 1, 0);
        addVec(1, 1, 0,  0,   1, 0, 0, 0, 0, 1, 0);
        addVec(0, 1, 0,  0,   1, 0, 0, 0, 0, 1, 0);
        addVec(0, 0, 0,  0,   1, 0, 0, 0, 0, 1, 0);
        addVec(0, 1, 5,  0,   0, 0, 1, 5, 1, 2, 0);
        addVec(0, 1, 9,  0,   0, 0, 1, 5, 1, 2, 0);
        addVec(0, 1, 9,  0,   0, 0, 1, 5, 1, 2, 0);
        addVec(0, 1, 9,  1,   1, 0, 0, 0, 0, 2, 0);
        addVec(0, 0, 0,  1,   1, 0, 0, 0, 0, 2, 0);
        addVec(0, 1, 0,  1,   0, 0, 2, 1, 1, 3, 0);
        addVec(0, 0, 0,  0,   0, 0, 2, 1, 1, 3, 0);
        addVec(0, 1, 12, 0,   0, 0, 2, 1, 2, 4, 0);
        addVec(0, 0, 0,  1,   0, 0, 3, 12, 1, 4, 0);
        addVec(0, 0, 0,  1,   1, 0, 0, 0, 0, 4, 0);
        addVec(0, 1, 4,  0,   0, 0, 4, 4, 1, 5, 0);
        addVec(1, 0, 0,  0,   1, 0, 0, 0, 0, 1, 0);
        addVec(0, 1, 6,  0,   0, 0, 1, 6, 1, 2, 0);
        addVec(1, 0, 0,  0,   1, 0, 0, 0, 0, 1, 0);
        addVec(0, 0, 0,  0,   1, 0, 0, 0, 0, 1, 0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rstV, vecs[i].arrV, vecs[i].stV, vecs[i].reV);
            checkOutput($sformatf("vec%0d.empty", i), empty, vecs[i].expEmpty);
            checkOutput($sformatf("vec%0d.full", i), full, vecs[i].expFull);
            checkOutput($sformatf("vec%0d.qn", i), qnOut, vecs[i].expQn);
            checkOutput($sformatf("vec%0d.qt", i), qtOut, vecs[i].expQt);
            checkOutput($sformatf("vec%0d.count", i), countOut, vecs[i].expCount);
            checkOutput($sformatf("vec%0d.next", i), nextNumOut, vecs[i].expNext);
            checkOutput($sformatf("vec%0d.drop", i), dropOut, vecs[i].expDrop);
        end

        // Fill to full with eight presses, then a ninth is dropped.
        applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 1, 3, 0);
            applyStimulus(0, 0, 3, 0);
        end
        checkOutput("fill.full", full, 1);
        checkOutput("fill.count", countOut, 8);
        checkOutput("fill.next", nextNumOut, 9);
        applyStimulus(0, 1, 3, 0);
        checkOutput("drop.pulse", dropOut, 1);
        checkOutput("drop.count", countOut, 8);
        checkOutput("drop.next", nextNumOut, 9);
        applyStimulus(0, 0, 3, 0);
        checkOutput("drop.clear", dropOut, 0);

        // Full with a coincident press and pop: accepted, head advances.
        applyStimulus(0, 1, 7, 1);
        checkOutput("fullpp.count", countOut, 8);
        checkOutput("fullpp.drop", dropOut, 0);
        checkOutput("fullpp.qn", qnOut, 2);
        checkOutput("fullpp.next", nextNumOut, 10);
        applyStimulus(0, 0, 0, 0);
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("drain%0d.qn", k), qnOut, k + 2);
            checkOutput($sformatf("drain%0d.qt", k), qtOut, (k == 7) ? 7 : 3);
            applyStimulus(0, 0, 0, 1);
        end
        checkOutput("drain.empty", empty, 1);

        // Seventeen tickets with zero service time: numbers skip 0 on wrap.
        applyStimulus(1, 0, 0, 0);
        for (int t = 0; t < 17; t++) begin
            applyStimulus(0, 1, 0, 0);
            checkOutput($sformatf("wrap%0d.qn", t), qnOut, (t % 15) + 1);
            checkOutput($sformatf("wrap%0d.qt", t), qtOut, 1);
            applyStimulus(0, 0, 0, 1);
            checkOutput($sformatf("wrap%0d.empty", t), empty, 1);
        end

        // Randomized traffic against the reference model.
        applyStimulus(1, 0, 0, 0);
        for (int c = 0; c < 600; c++) begin
            applyStimulus($urandom_range(0, 79) == 0,
                          $urandom_range(0, 1) == 1,
                          4'($urandom_range(0, 15)),
                          $urandom_range(0, 3) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
